// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: command sequencer and byte buffer placed directly upstream of SpiMaster.
//
// The host pushes transaction commands (slave index, length-1) and TX bytes. A transaction
// is launched towards the master only once its whole payload sits in the TX FIFO and the
// same number of free entries exists in the RX FIFO, so the master never starves and its
// replies never overflow.
//
// Ports
//   clk_i, rst_ni                 single clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o       command handshake; cmd_slave_i (0..23), cmd_len_i (N-1)
//   tx_valid_i/tx_ready_o         TX byte handshake, tx_data_i
//   rx_valid_o/rx_ready_i         RX FIFO head (first-word-fall-through), rx_data_o
//   tx_level_o, rx_level_o        FIFO occupancy, 0..DEPTH
//   done_o                        one-cycle pulse at the end of each transaction
//   err_o                         one-cycle pulse when a command is rejected
//   start_o, ss_mask_o,           master launch strobe and transaction parameters
//   trans_len_o
//   mread_i, mtx_d_o              master byte request and the byte handed to it
//   mvalid_i, mrx_d_i             master received-byte strobe and data
//   mbusy_i                       master transaction in progress
module spi_cmd_seq #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // Host command stream
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [4:0]    cmd_slave_i,
    input  logic [7:0]    cmd_len_i,
    // Host TX stream
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    input  logic [7:0]    tx_data_i,
    // Host RX stream
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic [7:0]    rx_data_o,
    // Status
    output logic [LW-1:0] tx_level_o,
    output logic [LW-1:0] rx_level_o,
    output logic          done_o,
    output logic          err_o,
    // SpiMaster side
    output logic          start_o,
    output logic [23:0]   ss_mask_o,
    output logic [7:0]    trans_len_o,
    input  logic          mread_i,
    output logic [7:0]    mtx_d_o,
    input  logic          mvalid_i,
    input  logic [7:0]    mrx_d_i,
    input  logic          mbusy_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StStart,
        StWaitBusy,
        StRun,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Out-of-reset flag: keeps both ready outputs low while reset is held,
    // so they rise only in the first cycle after reset deasserts.
    // ------------------------------------------------------------------
    logic active_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (host -> master)
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d;
    logic [AW-1:0] tx_rd_q, tx_rd_d;
    logic [LW-1:0] tx_level_q, tx_level_d;
    logic [7:0]    mtx_d_q, mtx_d_d;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full    = (tx_level_q == LW'(DEPTH));
    assign tx_empty   = (tx_level_q == '0);
    // A full FIFO stays not-ready even when the master pops in the same cycle.
    assign tx_ready_o = active_q & ~tx_full;
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign tx_pop     = mread_i & ~tx_empty;

    always_comb begin
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        tx_level_d = tx_level_q;
        mtx_d_d    = mtx_d_q;
        if (tx_push) begin
            tx_wr_d = tx_wr_q + AW'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + AW'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + LW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_level_d = tx_level_q - LW'(1);
        end
        // A request against an empty FIFO hands the master a zero byte.
        if (mread_i) begin
            mtx_d_d = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
            mtx_d_q    <= 8'h00;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_level_q <= tx_level_d;
            mtx_d_q    <= mtx_d_d;
        end
    end

    assign tx_level_o = tx_level_q;
    assign mtx_d_o    = mtx_d_q;

    // ------------------------------------------------------------------
    // RX FIFO (master -> host)
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_wr_d;
    logic [AW-1:0] rx_rd_q, rx_rd_d;
    logic [LW-1:0] rx_level_q, rx_level_d;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_level_q == LW'(DEPTH));
    assign rx_empty = (rx_level_q == '0);
    // Bytes arriving while full are dropped; reservation makes that unreachable normally.
    assign rx_push  = mvalid_i & ~rx_full;
    assign rx_pop   = rx_ready_i & ~rx_empty;

    always_comb begin
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        rx_level_d = rx_level_q;
        if (rx_push) begin
            rx_wr_d = rx_wr_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + AW'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + LW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_level_d = rx_level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q] <= mrx_d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else begin
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_level_q <= rx_level_d;
        end
    end

    assign rx_valid_o = ~rx_empty;
    // Masked to zero when empty so the head never shows uninitialised storage.
    assign rx_data_o  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
    assign rx_level_o = rx_level_q;

    // ------------------------------------------------------------------
    // Command sequencer
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [4:0] slave_q, slave_d;
    logic [7:0] len_q, len_d;
    logic       err_q, err_d;

    logic [8:0] cmd_n;      // byte count of the offered command
    logic [8:0] xfer_n;     // byte count of the latched command
    logic       cmd_reject;
    logic       tx_enough;
    logic       rx_space;

    assign cmd_n      = {1'b0, cmd_len_i} + 9'd1;
    assign xfer_n     = {1'b0, len_q} + 9'd1;
    assign cmd_reject = (cmd_slave_i > 5'd23) || (32'(cmd_n) > DEPTH);
    assign tx_enough  = (32'(tx_level_q) >= 32'(xfer_n));
    assign rx_space   = ((DEPTH - 32'(rx_level_q)) >= 32'(xfer_n));

    always_comb begin
        state_d     = state_q;
        slave_d     = slave_q;
        len_d       = len_q;
        err_d       = 1'b0;
        cmd_ready_o = 1'b0;
        start_o     = 1'b0;
        done_o      = 1'b0;
        ss_mask_o   = 24'h0;
        trans_len_o = 8'h00;

        unique case (state_q)
            StIdle: begin
                cmd_ready_o = active_q;
                if (cmd_valid_i && active_q) begin
                    if (cmd_reject) begin
                        err_d = 1'b1;
                    end else begin
                        slave_d = cmd_slave_i;
                        len_d   = cmd_len_i;
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (tx_enough && rx_space) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                start_o     = 1'b1;
                ss_mask_o   = 24'd1 << slave_q;
                trans_len_o = len_q;
                state_d     = StWaitBusy;
            end
            StWaitBusy: begin
                ss_mask_o   = 24'd1 << slave_q;
                trans_len_o = len_q;
                if (mbusy_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                ss_mask_o   = 24'd1 << slave_q;
                trans_len_o = len_q;
                if (!mbusy_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ss_mask_o   = 24'd1 << slave_q;
                trans_len_o = len_q;
                done_o      = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            slave_q <= 5'd0;
            len_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slave_q <= slave_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq: a table of commands driven through a small
// SpiMaster model, plus directed sequences for blocking, full/empty and reset corners.
module tb_spi_cmd_seq;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_slave = '0;
    logic [7:0]    cmd_len = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [7:0]    tx_data = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic [LW-1:0] tx_level, rx_level;
    logic          done, err, start;
    logic [23:0]   ss_mask;
    logic [7:0]    trans_len;
    logic          mread = 1'b0;
    logic [7:0]    mtx_d;
    logic          mvalid = 1'b0;
    logic [7:0]    mrx_d = '0;
    logic          mbusy = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_seq #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_slave_i (cmd_slave),
        .cmd_len_i   (cmd_len),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .tx_data_i   (tx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .rx_data_o   (rx_data),
        .tx_level_o  (tx_level),
        .rx_level_o  (rx_level),
        .done_o      (done),
        .err_o       (err),
        .start_o     (start),
        .ss_mask_o   (ss_mask),
        .trans_len_o (trans_len),
        .mread_i     (mread),
        .mtx_d_o     (mtx_d),
        .mvalid_i    (mvalid),
        .mrx_d_i     (mrx_d),
        .mbusy_i     (mbusy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] txb [16];
    logic [7:0] rxb [16];

    typedef struct {
        logic [4:0]  slave;
        logic [7:0]  len;
        logic        exp_err;
        logic [23:0] exp_mask;
        logic [31:0] d;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 50) begin
            tick();
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [4:0] s, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_slave = s;
        cmd_len   = l;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Entered in the START cycle; plays the master for n bytes through DONE.
    task automatic run_xfer(input int n, input logic [23:0] mask, input logic [7:0] len);
        chk("start", {31'd0, start}, 32'd1);
        chk("ss_mask", {8'd0, ss_mask}, {8'd0, mask});
        chk("trans_len", {24'd0, trans_len}, {24'd0, len});
        tick();
        chk("start_pulse", {31'd0, start}, 32'd0);
        chk("ss_mask_hold", {8'd0, ss_mask}, {8'd0, mask});
        mbusy = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            mread = 1'b1;
            tick();
            mread = 1'b0;
            chk("mtx_d", {24'd0, mtx_d}, {24'd0, txb[i]});
            mvalid = 1'b1;
            mrx_d  = rxb[i];
            tick();
            mvalid = 1'b0;
        end
        mbusy = 1'b0;
        chk("done_early", {31'd0, done}, 32'd0);
        tick();
        chk("done", {31'd0, done}, 32'd1);
        chk("ss_mask_done", {8'd0, ss_mask}, {8'd0, mask});
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("ss_mask_idle", {8'd0, ss_mask}, 32'd0);
    endtask

    task automatic drain_rx(input int n);
        for (int i = 0; i < n; i++) begin
            chk("rx_valid", {31'd0, rx_valid}, 32'd1);
            chk("rx_data", {24'd0, rx_data}, {24'd0, rxb[i]});
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        chk("rx_empty", {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{slave: 5'd2,  len: 8'd0,   exp_err: 1'b0, exp_mask: 24'h000004, d: 32'h000000a5};
        vecs[1] = '{slave: 5'd3,  len: 8'd3,   exp_err: 1'b0, exp_mask: 24'h000008, d: 32'h5a3ca5ff};
        vecs[2] = '{slave: 5'd24, len: 8'd0,   exp_err: 1'b1, exp_mask: 24'h000000, d: 32'h00000011};
        vecs[3] = '{slave: 5'd31, len: 8'd0,   exp_err: 1'b1, exp_mask: 24'h000000, d: 32'h00000022};
        vecs[4] = '{slave: 5'd0,  len: 8'd15,  exp_err: 1'b0, exp_mask: 24'h000001, d: 32'h44332211};
        vecs[5] = '{slave: 5'd0,  len: 8'd16,  exp_err: 1'b1, exp_mask: 24'h000000, d: 32'h00000033};
        vecs[6] = '{slave: 5'd23, len: 8'd1,   exp_err: 1'b0, exp_mask: 24'h800000, d: 32'h0000beef};
        vecs[7] = '{slave: 5'd5,  len: 8'd255, exp_err: 1'b1, exp_mask: 24'h000000, d: 32'h00000044};

        // Reset values and ready release
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_tx_level", {27'd0, tx_level}, 32'd0);
        chk("rst_rx_level", {27'd0, rx_level}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ss_mask", {8'd0, ss_mask}, 32'd0);
        chk("rst_mtx_d", {24'd0, mtx_d}, 32'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("cmd_ready_rise", {31'd0, cmd_ready}, 32'd1);
        chk("tx_ready_rise", {31'd0, tx_ready}, 32'd1);

        // Table of commands
        for (int v = 0; v < 8; v++) begin
            int n;
            n = int'(vecs[v].len) + 1;
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < n; i++) begin
                    txb[i] = (i < 4) ? vecs[v].d[8*i +: 8] : 8'(i * 29 + 7);
                    rxb[i] = 8'(8'h33 + i * 17);
                end
                for (int i = 0; i < n; i++) push_tx(txb[i]);
                chk("tx_level_loaded", {27'd0, tx_level}, 32'(n));
                send_cmd(vecs[v].slave, vecs[v].len);
                chk("err_legal", {31'd0, err}, 32'd0);
                chk("start_wait_data", {31'd0, start}, 32'd0);
                tick();
                run_xfer(n, vecs[v].exp_mask, vecs[v].len);
                chk("tx_level_end", {27'd0, tx_level}, 32'd0);
                chk("rx_level_end", {27'd0, rx_level}, 32'(n));
                drain_rx(n);
            end else begin
                push_tx(vecs[v].d[7:0]);
                send_cmd(vecs[v].slave, vecs[v].len);
                chk("err", {31'd0, err}, 32'd1);
                chk("start_rej", {31'd0, start}, 32'd0);
                chk("cmd_ready_rej", {31'd0, cmd_ready}, 32'd1);
                tick();
                chk("err_pulse", {31'd0, err}, 32'd0);
                chk("start_rej2", {31'd0, start}, 32'd0);
                tick();
                chk("start_rej3", {31'd0, start}, 32'd0);
                chk("tx_level_rej", {27'd0, tx_level}, 32'd1);
                chk("rx_level_rej", {27'd0, rx_level}, 32'd0);
                mread = 1'b1;
                tick();
                mread = 1'b0;
                chk("mtx_d_rej", {24'd0, mtx_d}, {24'd0, vecs[v].d[7:0]});
                chk("tx_level_rej_pop", {27'd0, tx_level}, 32'd0);
            end
        end

        // Partial payload: start waits for the fourth byte, then fires two cycles later
        for (int i = 0; i < 4; i++) begin
            txb[i] = 8'(8'h01 + i);
            rxb[i] = 8'(8'h71 + i);
        end
        push_tx(txb[0]);
        push_tx(txb[1]);
        send_cmd(5'd3, 8'd3);
        for (int j = 0; j < 4; j++) begin
            chk("partial_hold", {31'd0, start}, 32'd0);
            tick();
        end
        push_tx(txb[2]);
        chk("partial_hold3", {31'd0, start}, 32'd0);
        push_tx(txb[3]);
        chk("partial_hold4", {31'd0, start}, 32'd0);
        tick();
        run_xfer(4, 24'h8, 8'd3);
        drain_rx(4);

        // RX reservation: DEPTH-1 bytes held, 2-byte command blocks until one pop
        mvalid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            mrx_d = 8'(8'h80 + i);
            tick();
        end
        mvalid = 1'b0;
        chk("rx_fill_level", {27'd0, rx_level}, 32'd15);
        chk("rx_fill_head", {24'd0, rx_data}, 32'h80);
        txb[0] = 8'hc1; txb[1] = 8'hc2;
        rxb[0] = 8'hd1; rxb[1] = 8'hd2;
        push_tx(txb[0]);
        push_tx(txb[1]);
        send_cmd(5'd1, 8'd1);
        for (int j = 0; j < 5; j++) begin
            chk("rx_block", {31'd0, start}, 32'd0);
            tick();
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_block_after_pop", {31'd0, start}, 32'd0);
        chk("rx_level_pop", {27'd0, rx_level}, 32'd14);
        tick();
        run_xfer(2, 24'h2, 8'd1);
        chk("rx_level_full", {27'd0, rx_level}, 32'd16);
        mvalid = 1'b1;
        mrx_d  = 8'hff;
        tick();
        mvalid = 1'b0;
        chk("rx_drop_full", {27'd0, rx_level}, 32'd16);
        for (int i = 0; i < 14; i++) begin
            chk("rx_fill_data", {24'd0, rx_data}, 32'(8'h81 + i));
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        drain_rx(2);

        // TX full, refused push with simultaneous pop, empty read
        for (int i = 0; i < 16; i++) begin
            txb[i] = 8'(8'h40 + i);
            push_tx(txb[i]);
        end
        chk("tx_full_level", {27'd0, tx_level}, 32'd16);
        chk("tx_full_ready", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'hee;
        tick();
        chk("tx_full_refuse", {27'd0, tx_level}, 32'd16);
        mread = 1'b1;
        tick();
        mread    = 1'b0;
        tx_valid = 1'b0;
        chk("tx_full_pop_data", {24'd0, mtx_d}, {24'd0, txb[0]});
        chk("tx_full_pop_level", {27'd0, tx_level}, 32'd15);
        for (int i = 1; i < 16; i++) begin
            mread = 1'b1;
            tick();
            mread = 1'b0;
            chk("tx_drain", {24'd0, mtx_d}, {24'd0, txb[i]});
        end
        chk("tx_drained", {27'd0, tx_level}, 32'd0);
        mread = 1'b1;
        tick();
        mread = 1'b0;
        chk("mread_empty", {24'd0, mtx_d}, 32'd0);
        chk("mread_empty_level", {27'd0, tx_level}, 32'd0);
        push_tx(8'h11);
        tx_valid = 1'b1;
        tx_data  = 8'h22;
        mread    = 1'b1;
        tick();
        tx_valid = 1'b0;
        mread    = 1'b0;
        chk("tx_push_pop_level", {27'd0, tx_level}, 32'd1);
        chk("tx_push_pop_data", {24'd0, mtx_d}, 32'h11);
        mread = 1'b1;
        tick();
        mread = 1'b0;
        chk("tx_push_pop_second", {24'd0, mtx_d}, 32'h22);

        // Reset during RUN, then a clean 1-byte transaction
        push_tx(8'h5e);
        send_cmd(5'd7, 8'd0);
        tick();
        tick();
        mbusy = 1'b1;
        tick();
        push_tx(8'h99);
        mread = 1'b1;
        tick();
        mread  = 1'b0;
        mvalid = 1'b1;
        mrx_d  = 8'h44;
        tick();
        mvalid = 1'b0;
        rst_n  = 1'b0;
        mbusy  = 1'b0;
        tick();
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_tx_level", {27'd0, tx_level}, 32'd0);
        chk("mid_rst_rx_level", {27'd0, rx_level}, 32'd0);
        chk("mid_rst_ss_mask", {8'd0, ss_mask}, 32'd0);
        chk("mid_rst_trans_len", {24'd0, trans_len}, 32'd0);
        chk("mid_rst_mtx_d", {24'd0, mtx_d}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_start", {31'd0, start}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        txb[0] = 8'h6b;
        rxb[0] = 8'h2d;
        push_tx(txb[0]);
        send_cmd(5'd7, 8'd0);
        tick();
        run_xfer(1, 24'h80, 8'd0);
        drain_rx(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_seq.md
# spi_cmd_seq

Command sequencer and byte buffer in front of `SpiMaster`. Accepts transaction commands (slave index and length) plus TX bytes from a host-side stream, and launches each transaction only when its full payload is buffered and RX space is reserved. Serves the master's byte-request strobe and collects received bytes into an RX FIFO for the host. Sits directly upstream of `SpiMaster` and replaces hand-driven `start`/`ss_mask`/`trans_len` stimulus.

## Interface
Parameters:
- `DEPTH`, 16: TX and RX FIFO depth in bytes; power of two, 2..256.
- `LW`, `$clog2(DEPTH)+1`: width of the level outputs.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid & cmd_ready`.
- `cmd_slave` in 5: slave index, 0..23.
- `cmd_len` in 8: byte count minus 1.
- `tx_valid` in 1: TX byte offered.
- `tx_ready` out 1: TX byte accepted on `tx_valid & tx_ready`.
- `tx_data` in 8: TX byte.
- `rx_valid` out 1: RX FIFO non-empty; data is first-word-fall-through.
- `rx_ready` in 1: pops the RX FIFO when `rx_valid` is high.
- `rx_data` out 8: RX FIFO head.
- `tx_level`, `rx_level` out LW: FIFO occupancy.
- `done` out 1: one-cycle pulse at the end of each transaction.
- `err` out 1: one-cycle pulse when a command is rejected.
- `start` out 1: to master, one-cycle pulse.
- `ss_mask` out 24: to master, one-hot `1<<cmd_slave`.
- `trans_len` out 8: to master, equals `cmd_len`.
- `mread` in 1: master requests the next TX byte.
- `mtx_d` out 8: TX byte to master.
- `mvalid` in 1: master has a received byte.
- `mrx_d` in 8: received byte.
- `mbusy` in 1: master transaction in progress.

## Operation
- States: IDLE, WAIT_DATA, START, WAIT_BUSY, RUN, DONE.
- IDLE: `cmd_ready=1`. On accept, latch slave and length (N = `cmd_len`+1).
  - If `cmd_slave>23` or N>DEPTH: pulse `err`, drop the command, stay in IDLE.
  - Otherwise go to WAIT_DATA.
- WAIT_DATA: wait until `tx_level>=N` and `DEPTH-rx_level>=N`, then go to START.
  - TX bytes may keep arriving during this and every other state.
- START: `start=1` for exactly one cycle, then go to WAIT_BUSY.
- `ss_mask` and `trans_len` are driven from START through DONE; they are 0 in every other state.
- WAIT_BUSY: go to RUN when `mbusy=1`.
- RUN: go to DONE when `mbusy=0`.
- DONE: `done=1` for one cycle, then go to IDLE.
- `mread` (any state): pop the TX FIFO head into the `mtx_d` register on the same edge.
  - `mread` with TX empty: `mtx_d` <= 8'h00, no pop. This cannot occur in legal operation.
- `mvalid`: push `mrx_d` into the RX FIFO. Space was reserved in WAIT_DATA, so overflow cannot occur.
  - `mvalid` while full: drop the byte.
- TX FIFO:
  - `tx_ready = ~full`.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - A full FIFO stays not-ready even if a pop occurs that cycle.
- RX FIFO: push via `mvalid` and pop via `rx_ready` in the same cycle are both honoured.
- Pointers wrap modulo DEPTH. Levels range 0..DEPTH.

## Timing
- Reset values: `cmd_ready=0`, `tx_ready=0`, `rx_valid=0`, `rx_data=0`, `tx_level=0`, `rx_level=0`, `done=0`, `err=0`, `start=0`, `ss_mask=0`, `trans_len=0`, `mtx_d=0`.
- Reset clears both FIFOs and returns the FSM to IDLE, including mid-transaction. The master shares the same reset.
- `cmd_ready` and `tx_ready` rise in the first cycle after `rst` deasserts.
- Command accepted at edge k with data and space already present: `start` is high in cycle k+2 (WAIT_DATA check in k+1, START in k+2).
- `err` is high in cycle k+1 after a rejected accept at edge k.
- `mread` at edge n: `mtx_d` is valid from n+1 until the next `mread`.
- `mvalid` at edge n: byte is visible on `rx_data` from n+1 if the FIFO was empty.
- `done` follows the first `mbusy=0` sample in RUN by one cycle.
- `cmd_ready` returns the cycle after `done`.
- Throughput limit is one command per (transaction + 4) cycles.

## Test plan
- Push 8'ha5, then cmd slave=2 len=0 -> `start` one cycle, `ss_mask`=24'h4, `trans_len`=0. First `mread` yields `mtx_d`=8'ha5. Slave reply 8'h33 appears on `rx_data`. One `done` pulse.
- Push ff,a5,3c,5a, then cmd slave=3 len=3 -> four `mread`s return bytes in order. RX holds 4 bytes. `tx_level` ends at 0.
- Cmd slave=3 len=3 with only 2 bytes buffered -> `start` stays 0 until the 4th byte is pushed, then fires 2 cycles later.
- Cmd slave=24, and separately cmd len=DEPTH (N=DEPTH+1) -> `err` pulse each time, no `start`, levels unchanged.
- Hold `rx_ready=0` with RX containing DEPTH-1 bytes, then issue a 2-byte command -> blocked in WAIT_DATA. Popping one byte releases `start`.
- Assert `rst=0` for one cycle during RUN -> all outputs at reset values next cycle, levels 0, FSM in IDLE. A following 1-byte transaction completes correctly.
